// File: rtl/exfifo_pkt_bridge.sv
// Byte-stream <-> 32-bit word bridge for the CPU control-packet exchange FIFOs.
// RX packs host bytes little-endian into exfifo_if; TX serialises exfifo_of words to the host.
`timescale 1ns/1ps
module exfifo_pkt_bridge #(
  parameter int PKT_BYTES   = 64,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_exfifo_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [31:0] o_if_d,
  output logic        o_if_wr,
  input  logic        i_if_wrfull,
  input  logic [31:0] i_of_d,
  output logic        o_of_rd,
  input  logic        i_of_rdempty,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_tx_last,
  output logic [15:0] o_rx_pkt_cnt,
  output logic [7:0]  o_rx_timeout_cnt
);
  localparam int IW = $clog2(PKT_BYTES);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(PKT_BYTES - 1);
  localparam logic [TW-1:0] TMO      = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PAD} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_RD, TX_LOAD, TX_SEND} tx_state_t;

  rx_state_t      r_rx_state, w_rx_next;
  tx_state_t      r_tx_state, w_tx_next;
  logic [IW-1:0]  r_rx_idx, r_tx_idx, w_tx_idx_nxt;
  logic [23:0]    r_acc, r_sh;
  logic [31:0]    r_hold;
  logic           r_word_pending;
  logic [TW-1:0]  r_timer;
  logic [15:0]    r_pkt_cnt;
  logic [7:0]     r_tmo_cnt, r_tx_data;
  logic           r_of_rd, r_tx_valid, r_tx_last;
  logic           w_flush, w_rx_ready, w_rx_acc, w_pad_push, w_push, w_rx_last;
  logic           w_if_wr, w_tmo, w_tmr_run, w_tx_hs;
  logic [7:0]     w_byte;

  assign w_flush    = i_reset | i_exfifo_rst;
  assign w_rx_ready = ~r_word_pending & (r_rx_state != RX_PAD);
  assign w_rx_acc   = i_rx_valid & w_rx_ready;
  assign w_pad_push = (r_rx_state == RX_PAD) & ~r_word_pending;
  assign w_push     = w_rx_acc | w_pad_push;
  assign w_byte     = w_pad_push ? 8'h00 : i_rx_data;
  assign w_rx_last  = (r_rx_idx == IDX_LAST);
  assign w_if_wr    = r_word_pending & ~i_if_wrfull;
  assign w_tmo      = (r_timer == TMO);
  // A FIFO-full stall holds the timer at zero so back-pressure never pads a packet.
  assign w_tmr_run  = (r_rx_state == RX_DATA) & ~w_rx_acc & ~(r_word_pending & i_if_wrfull) & ~w_tmo;

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE: if (w_rx_acc) w_rx_next = RX_DATA;
      RX_DATA: begin
        if (w_rx_acc && w_rx_last)  w_rx_next = RX_IDLE;
        else if (!w_rx_acc && w_tmo) w_rx_next = RX_PAD;
      end
      RX_PAD:  if (w_pad_push && w_rx_last) w_rx_next = RX_IDLE;
      default: w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_flush) begin
      r_rx_state     <= RX_IDLE;
      r_rx_idx       <= '0;
      r_acc          <= '0;
      r_hold         <= '0;
      r_word_pending <= 1'b0;
      r_timer        <= '0;
    end else begin
      r_rx_state <= w_rx_next;
      if (w_if_wr) r_word_pending <= 1'b0;
      if (w_push) begin
        r_rx_idx <= w_rx_last ? '0 : r_rx_idx + 1'b1;
        case (r_rx_idx[1:0])
          2'd0:    r_acc[7:0]   <= w_byte;
          2'd1:    r_acc[15:8]  <= w_byte;
          2'd2:    r_acc[23:16] <= w_byte;
          default: begin
            r_hold         <= {w_byte, r_acc};
            r_word_pending <= 1'b1;
          end
        endcase
      end
      r_timer <= w_tmr_run ? r_timer + 1'b1 : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pkt_cnt <= '0;
      r_tmo_cnt <= '0;
    end else if (!i_exfifo_rst && w_push && w_rx_last) begin
      r_pkt_cnt <= r_pkt_cnt + 1'b1;
      if (w_pad_push && r_tmo_cnt != 8'hFF) r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_tx_hs      = r_tx_valid & i_tx_ready;
  assign w_tx_idx_nxt = (r_tx_idx == IDX_LAST) ? '0 : r_tx_idx + 1'b1;

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE: if (!i_of_rdempty) w_tx_next = TX_RD;
      TX_RD:   w_tx_next = TX_LOAD;
      TX_LOAD: w_tx_next = TX_SEND;
      TX_SEND: if (w_tx_hs && r_tx_idx[1:0] == 2'd3) w_tx_next = i_of_rdempty ? TX_IDLE : TX_RD;
      default: w_tx_next = TX_IDLE;
    endcase
  end

  // r_sh holds the not-yet-presented upper bytes of the current word.
  always_ff @(posedge i_clk) begin
    if (w_flush) begin
      r_tx_state <= TX_IDLE;
      r_tx_idx   <= '0;
      r_of_rd    <= 1'b0;
      r_sh       <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_tx_last  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      r_of_rd    <= (w_tx_next == TX_RD);
      if (r_tx_state == TX_LOAD) begin
        r_sh       <= i_of_d[31:8];
        r_tx_data  <= i_of_d[7:0];
        r_tx_valid <= 1'b1;
        r_tx_last  <= (r_tx_idx == IDX_LAST);
      end else if (w_tx_hs) begin
        r_tx_idx <= w_tx_idx_nxt;
        r_sh     <= {8'h00, r_sh[23:8]};
        if (r_tx_idx[1:0] == 2'd3) begin
          r_tx_valid <= 1'b0;
          r_tx_last  <= 1'b0;
        end else begin
          r_tx_data <= r_sh[7:0];
          r_tx_last <= (w_tx_idx_nxt == IDX_LAST);
        end
      end
    end
  end

  assign o_rx_ready       = w_rx_ready;
  assign o_if_wr          = w_if_wr;
  assign o_if_d           = r_hold;
  assign o_of_rd          = r_of_rd;
  assign o_tx_data        = r_tx_data;
  assign o_tx_valid       = r_tx_valid;
  assign o_tx_last        = r_tx_last;
  assign o_rx_pkt_cnt     = r_pkt_cnt;
  assign o_rx_timeout_cnt = r_tmo_cnt;
endmodule

// File: doc/exfifo_pkt_bridge.md
# exfifo_pkt_bridge

Byte-stream to 32-bit word bridge around the NIOS/PicoRV32 control-packet exchange FIFOs. On the receive side it packs host control-packet bytes into little-endian 32-bit words and writes them into the CPU's input FIFO (`exfifo_if`). On the transmit side it drains the CPU's output FIFO (`exfifo_of`) and serialises each word back into bytes for the host link. Packets are fixed length; incomplete receive packets are zero-padded after an idle timeout.

## Interface
- `PKT_BYTES`, 64: packet length in bytes; multiple of 4, range 8..256.
- `TIMEOUT_CYC`, 65535: idle cycles inside a partial RX packet before padding; ≥ 2.

- `clk` in 1: single clock; all logic rising-edge.
- `reset` in 1: synchronous, active-high.
- `exfifo_rst` in 1: synchronous datapath flush from the CPU; same effect as `reset` except status counters are kept.
- `rx_data` in 8: host byte.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: byte accepted when `rx_valid & rx_ready`.
- `if_d` out 32: word to the input FIFO.
- `if_wr` out 1: FIFO write strobe.
- `if_wrfull` in 1: input FIFO full.
- `of_d` in 32: output FIFO data, valid one cycle after `of_rd` (normal, non-show-ahead mode).
- `of_rd` out 1: output FIFO read strobe.
- `of_rdempty` in 1: output FIFO empty.
- `tx_data` out 8: host byte.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: byte consumed when `tx_valid & tx_ready`.
- `tx_last` out 1: qualifies the final byte of a `PKT_BYTES` packet.
- `rx_pkt_cnt` out 16: wrapping count of completed RX packets, padded ones included.
- `rx_timeout_cnt` out 8: count of padded packets; saturates at 255.

## Operation
- RX packing: byte k of a word goes to bits [8k+7:8k]; the first byte of a packet lands in bits [7:0] of word 0.
- `rx_byte_idx` counts 0..`PKT_BYTES`-1 and wraps to 0 after the last byte.
- Fourth byte accepted: the assembled word moves to the holding register and `word_pending` is set.
- `if_wr = word_pending & ~if_wrfull`. `word_pending` clears on the write cycle.
- `rx_ready = ~word_pending & ~padding`.
- Full FIFO: back-pressure only. No word is ever dropped.
- RX states:
  - RX_IDLE: `rx_byte_idx`=0. First byte accepted → RX_DATA.
  - RX_DATA: accepts bytes. Last byte accepted → RX_IDLE and `rx_pkt_cnt`+1. Idle timer reaches `TIMEOUT_CYC` → RX_PAD.
  - RX_PAD: inserts one 0x00 byte per cycle, subject to the same `word_pending` stall. After the last pad byte → RX_IDLE, `rx_pkt_cnt`+1, `rx_timeout_cnt`+1 (saturating).
- Idle timer: counts cycles in RX_DATA with no accepted byte. It resets on every accepted byte and while `word_pending` is stalled by `if_wrfull`; FIFO stalls never cause padding.
- TX states:
  - TX_IDLE: `~of_rdempty` → TX_RD.
  - TX_RD: `of_rd`=1 for exactly one cycle → TX_LOAD.
  - TX_LOAD: captures `of_d` into the shift register → TX_SEND.
  - TX_SEND: presents byte 0..3, LSB first, advancing on each `tx_valid & tx_ready`. After byte 3: → TX_RD if `~of_rdempty`, else TX_IDLE.
- `tx_byte_idx` counts 0..`PKT_BYTES`-1; `tx_last`=1 when it equals `PKT_BYTES`-1.
- `exfifo_rst` or `reset`: RX/TX return to IDLE, byte indices 0, `word_pending`=0, timer 0, any partial word discarded. `reset` also clears `rx_pkt_cnt` and `rx_timeout_cnt`.
- Flush taking effect while `of_rd` is high: the word read is discarded.

## Timing
- Reset values: `rx_ready`=1, `if_wr`=0, `if_d`=0, `of_rd`=0, `tx_valid`=0, `tx_data`=0, `tx_last`=0, both counters 0. `rx_ready` is 1 in the cycle after reset.
- RX latency: 4th byte accepted at edge N → `if_wr`=1 in cycle N+1 if not full. `rx_ready`=0 in cycle N+1, returns to 1 at N+2.
- Sustained RX throughput: 4 bytes per 5 cycles.
- TX latency: `of_rdempty`=0 sampled at edge N → `of_rd`=1 in cycle N+1 → data captured in N+2 → `tx_valid`=1 from N+3.
- `of_rd`, `tx_valid`, `tx_data`, `tx_last` are registered. `if_wr` and `rx_ready` are combinational from registers plus `if_wrfull`.
- `tx_data` and `tx_last` hold stable while `tx_valid & ~tx_ready`.
- Timeout: padding starts at the cycle after the timer equals `TIMEOUT_CYC`.

## Test plan
- Bytes 0x01..0x40, contiguous, FIFO never full → 16 writes. First `if_d`=0x04030201, last `if_d`=0x403F3E3D; `rx_pkt_cnt`=1.
- Same stream with `if_wrfull` held high for 20 cycles after word 3 → no `if_wr` while full, all 16 words in order, no timeout.
- 10 bytes then silence, `TIMEOUT_CYC`=100 → padding starts 101 cycles after the last byte. Word 2 = 0x00000A09; 16 words total; `rx_timeout_cnt`=1.
- Output FIFO preloaded with 16 words, 0x44332211 repeated, `tx_ready`=1 → bytes 11,22,33,44 repeating; `of_rd` pulses once per word; `tx_last` only on byte 63.
- Random `tx_ready` toggling → no byte lost or duplicated; `tx_data` stable while stalled.
- `exfifo_rst` pulsed after 6 RX bytes and mid-TX word → both sides return to IDLE. The next packet starts fresh at byte 0 with word 0 correct; `rx_pkt_cnt` is unchanged.
